// File: rtl/crossbar_pkg.sv
// Shared widths and FSM encoding for the two-master slave arbiter.
package crossbar_pkg;
    localparam int ADDR_W = 31;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: combinational one-hot grant, no backpressure of its own.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/slave_arbiter.sv
// Shares one slave between two masters; req->ack is 3 cycles with a one-cycle slave.
// Masters hold req until ack; the slave is given TIMEOUT cycles before an error completion.
module slave_arbiter
    import crossbar_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_resp,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_resp,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_cmd,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic              s_resp,
    input  logic [DATA_W-1:0] s_rdata
);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic              ptr;
    logic              win;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        gnt;
    logic              timed_out;
    logic [1:0]        ack_q, resp_q, err_q;
    logic [DATA_W-1:0] rdata_q [2];

    rr_pick2 u_pick (
        .req ({m1_req, m0_req}),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign timed_out = (cnt + CNT_W'(1)) == TO_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|gnt) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_WAIT;
            ST_WAIT:  if (s_ack || timed_out) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            win        <= 1'b0;
            cnt        <= '0;
            s_req      <= 1'b0;
            s_cmd      <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            ack_q      <= '0;
            resp_q     <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        win     <= gnt[1];
                        s_req   <= 1'b1;
                        s_cmd   <= gnt[1] ? m1_cmd   : m0_cmd;
                        s_addr  <= gnt[1] ? m1_addr  : m0_addr;
                        s_wdata <= gnt[1] ? m1_wdata : m0_wdata;
                    end
                end
                ST_GRANT: begin
                    s_req <= 1'b0;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (s_ack) begin
                        ack_q[win]  <= 1'b1;
                        resp_q[win] <= s_resp;
                        err_q[win]  <= 1'b0;
                        if (!s_cmd) rdata_q[win] <= s_rdata;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Error completion zeroes read data so a stale value is never mistaken for a result.
                        if (timed_out) begin
                            ack_q[win]   <= 1'b1;
                            resp_q[win]  <= 1'b0;
                            err_q[win]   <= 1'b1;
                            rdata_q[win] <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    ack_q  <= '0;
                    resp_q <= '0;
                    err_q  <= '0;
                    ptr    <= ~win;
                end
                default: ;
            endcase
        end
    end

    assign m0_ack   = ack_q[0];
    assign m0_resp  = resp_q[0];
    assign m0_err   = err_q[0];
    assign m0_rdata = rdata_q[0];
    assign m1_ack   = ack_q[1];
    assign m1_resp  = resp_q[1];
    assign m1_err   = err_q[1];
    assign m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_slave_arbiter.sv
// Randomized bench for slave_arbiter: timeline reference model plus directed literal checks.
module tb_slave_arbiter;
    localparam int TO = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mreq [2];
    logic        mcmd [2];
    logic [30:0] maddr [2];
    logic [31:0] mwdata [2];
    logic        s_ack, s_resp;
    logic [31:0] s_rdata;
    wire         m0_ack, m0_resp, m0_err, m1_ack, m1_resp, m1_err;
    wire  [31:0] m0_rdata, m1_rdata;
    wire         s_req, s_cmd;
    wire  [30:0] s_addr;
    wire  [31:0] s_wdata;

    logic [1:0]  mack, mresp, merr;
    logic [31:0] mrdata [2];
    always_comb begin
        mack      = {m1_ack, m0_ack};
        mresp     = {m1_resp, m0_resp};
        merr      = {m1_err, m0_err};
        mrdata[0] = m0_rdata;
        mrdata[1] = m1_rdata;
    end

    slave_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(mreq[0]), .m0_cmd(mcmd[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
        .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(mreq[1]), .m1_cmd(mcmd[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
        .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction granted at edge g drops s_req at g+1, may be acked on
    // edges g+2..g+1+TO (error at the last one), and shows its completion for one cycle.
    int          n, g;
    bit          busy, done, rr, win, c_cmd;
    logic [30:0] c_addr;
    logic [31:0] c_wd;
    logic        e_sreq;
    logic [1:0]  e_ack, e_resp, e_err;
    logic [31:0] e_rdata [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; busy = 0; done = 0; rr = 0; win = 0;
            e_sreq = 0; c_cmd = 0; c_addr = '0; c_wd = '0;
            e_ack = '0; e_resp = '0; e_err = '0;
            e_rdata[0] = '0; e_rdata[1] = '0;
        end else begin
            n++;
            if (busy && done) begin
                e_ack = '0; e_resp = '0; e_err = '0;
                rr = !win; busy = 0; done = 0;
            end else if (busy) begin
                if (n == g + 1) begin
                    e_sreq = 0;
                end else if (s_ack) begin
                    e_ack[win] = 1'b1; e_resp[win] = s_resp; e_err[win] = 1'b0;
                    if (!c_cmd) e_rdata[win] = s_rdata;
                    done = 1;
                end else if (n == g + 1 + TO) begin
                    e_ack[win] = 1'b1; e_resp[win] = 1'b0; e_err[win] = 1'b1;
                    e_rdata[win] = '0;
                    done = 1;
                end
            end else if (mreq[0] || mreq[1]) begin
                win    = (mreq[0] && mreq[1]) ? rr : mreq[1];
                c_cmd  = mcmd[win];
                c_addr = maddr[win];
                c_wd   = mwdata[win];
                e_sreq = 1;
                busy   = 1;
                g      = n;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_sreq", s_req, e_sreq);
            chk("m_scmd", s_cmd, c_cmd);
            chk("m_saddr", s_addr, c_addr);
            chk("m_swdata", s_wdata, c_wd);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m_ack%0d", i), mack[i], e_ack[i]);
                chk($sformatf("m_resp%0d", i), mresp[i], e_resp[i]);
                chk($sformatf("m_err%0d", i), merr[i], e_err[i]);
                chk($sformatf("m_rdata%0d", i), mrdata[i], e_rdata[i]);
            end
        end
    end

    // Stimulus: masters and slave are stepped on the falling edge.
    int          mode;      // 0 memory slave, 1 random noise, 2 silent, 3 constant ack
    bit          auto_m [2];
    bit          persist [2];
    logic [30:0] paddr [2];
    bit          pend, p_cmd;
    logic [30:0] p_addr;
    logic [31:0] p_wd;
    logic [31:0] mem [32];

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (mreq[i] && mack[i]) begin
                mreq[i] = 1'b0;
            end else if (mreq[i] && auto_m[i] && $urandom_range(3) == 0) begin
                maddr[i] = 31'($urandom);
            end else if (!mreq[i] && persist[i]) begin
                mreq[i] = 1'b1; mcmd[i] = 1'b0; maddr[i] = paddr[i];
            end else if (!mreq[i] && auto_m[i] && $urandom_range(1) == 0) begin
                mreq[i]   = 1'b1;
                mcmd[i]   = 1'($urandom_range(1));
                maddr[i]  = {26'd0, 5'($urandom)};
                mwdata[i] = $urandom;
            end
        end
        case (mode)
            0: begin
                s_ack = 0; s_resp = 0; s_rdata = '0;
                if (pend) begin
                    s_ack = 1; s_resp = !p_cmd;
                    if (p_cmd) mem[p_addr[4:0]] = p_wd;
                    else       s_rdata = mem[p_addr[4:0]];
                    pend = 0;
                end else if (s_req) begin
                    pend = 1; p_cmd = s_cmd; p_addr = s_addr; p_wd = s_wdata;
                end
            end
            1: begin
                s_ack = ($urandom_range(2) == 0); s_resp = 1'($urandom_range(1)); s_rdata = $urandom;
            end
            3: begin
                s_ack = 1; s_resp = 1; s_rdata = $urandom;
            end
            default: begin
                s_ack = 0; s_resp = 0; s_rdata = '0;
            end
        endcase
    endtask

    task automatic wait_done(input int i, output int lat, output int hi, output logic [30:0] ga,
                             output logic [31:0] gd, output logic gc, output bit other);
        lat = 0; hi = 0; ga = '0; gd = '0; gc = 0; other = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            lat++;
            if (s_req) begin hi++; ga = s_addr; gd = s_wdata; gc = s_cmd; end
            if (mack[1-i]) other = 1;
            if (mack[i]) return;
        end
        lat = -1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        mreq[0] = 0; mreq[1] = 0; pend = 0;
        tick();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int          lat, hi, w, ng;
    logic [30:0] ga;
    logic [31:0] gd;
    logic        gc;
    bit          other, seen, got, any_ack, any_sreq;
    logic [30:0] grants [6];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 0; mcmd[i] = 0; maddr[i] = '0; mwdata[i] = '0;
            auto_m[i] = 0; persist[i] = 0; paddr[i] = '0;
        end
        s_ack = 0; s_resp = 0; s_rdata = '0; mode = 0; pend = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        tick();
        chk("rst_sreq", s_req, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_swdata", s_wdata, 0);
        chk("rst_acks", mack, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rdata1", m1_rdata, 0);

        // Single write from m0
        mreq[0] = 1; mcmd[0] = 1; maddr[0] = 31'd5; mwdata[0] = 32'hDEADBEEF;
        wait_done(0, lat, hi, ga, gd, gc, other);
        chk("wr_latency", lat, 3);
        chk("wr_sreq_cycles", hi, 1);
        chk("wr_saddr", ga, 5);
        chk("wr_swdata", gd, 32'hDEADBEEF);
        chk("wr_scmd", gc, 1);
        chk("wr_resp", m0_resp, 0);
        chk("wr_err", m0_err, 0);
        chk("wr_m1_ack", other, 0);
        chk("wr_m1_rdata", m1_rdata, 0);

        // Read-back from m1
        tick();
        mreq[1] = 1; mcmd[1] = 0; maddr[1] = 31'd5;
        wait_done(1, lat, hi, ga, gd, gc, other);
        chk("rd_latency", lat, 3);
        chk("rd_resp", m1_resp, 1);
        chk("rd_err", m1_err, 0);
        chk("rd_rdata", m1_rdata, 32'hDEADBEEF);
        chk("rd_m0_ack", other, 0);
        chk("rd_m0_rdata", m0_rdata, 0);

        // m0 reads so the later timeout visibly clears rdata
        tick();
        mreq[0] = 1; mcmd[0] = 0; maddr[0] = 31'd5;
        wait_done(0, lat, hi, ga, gd, gc, other);
        chk("rd0_rdata", m0_rdata, 32'hDEADBEEF);

        // Timeout with a silent slave
        tick();
        mode = 2;
        mreq[0] = 1; mcmd[0] = 0; maddr[0] = 31'd7;
        w = -1; seen = 0; got = 0; other = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (s_req) seen = 1;
            else if (seen && w < 0) w = 0;
            else if (w >= 0) w++;
            if (mack[1]) other = 1;
            if (mack[0]) begin got = 1; break; end
        end
        chk("to_ack_seen", got, 1);
        chk("to_wait_cycles", w, TO);
        chk("to_err", m0_err, 1);
        chk("to_resp", m0_resp, 0);
        chk("to_rdata", m0_rdata, 0);
        chk("to_m1_ack", other, 0);
        chk("to_m1_rdata", m1_rdata, 32'hDEADBEEF);

        // Reset while waiting; the pointer (now at m1) must return to m0
        tick();
        mreq[0] = 1; mcmd[0] = 1; maddr[0] = 31'd9; mwdata[0] = 32'h1234_5678;
        tick();
        chk("rw_grant", s_req, 1);
        tick();
        chk("rw_in_wait", s_req, 0);
        do_reset();
        mode = 3;
        any_ack = 0; any_sreq = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (mack != 0) any_ack = 1;
            if (s_req) any_sreq = 1;
        end
        chk("rw_no_ack", any_ack, 0);
        chk("rw_no_sreq", any_sreq, 0);
        chk("rw_rdata0", m0_rdata, 0);

        // Contention, then continuous re-requesting
        mode = 0; pend = 0;
        paddr[0] = 31'd11; paddr[1] = 31'd22;
        persist[0] = 1; persist[1] = 1;
        ng = 0;
        for (int t = 0; t < 60 && ng < 6; t++) begin
            tick();
            if (s_req) begin grants[ng] = s_addr; ng++; end
        end
        persist[0] = 0; persist[1] = 0;
        chk("rr_grant_count", ng, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_order%0d", i), grants[i], (i % 2 == 0) ? 31'd11 : 31'd22);
        end
        repeat (12) tick();

        // Randomized traffic: noisy slave with a reset in the middle, then memory slave
        auto_m[0] = 1; auto_m[1] = 1;
        mode = 1;
        repeat (400) tick();
        do_reset();
        repeat (400) tick();
        mode = 0; pend = 0;
        repeat (600) tick();
        auto_m[0] = 0; auto_m[1] = 0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
